// File: rtl/wb_stage.sv
// Write-back stage: a single stage register feeding register-file, icc and Y writes.
// Load extraction is big-endian. Double-word writes take two cycles (high word, then low word).
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Wb_regD_in,
  input  logic [63:0] Wb_alures_in,
  input  logic [63:0] Wb_load_data_in,
  input  logic [1:0]  Wb_op_in,
  input  logic [2:0]  Wb_op2_in,
  input  logic [5:0]  Wb_op3_in,
  input  logic        Wb_regWrite_in,
  input  logic        Wb_regWriteDouble_in,
  input  logic [3:0]  Wb_icc_in,
  input  logic        Wb_icc_write_in,
  input  logic [31:0] Wb_Y_in,
  input  logic        Wb_Y_write_in,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        icc_we,
  output logic [3:0]  icc_out,
  output logic        y_we,
  output logic [31:0] y_out,
  output logic        wb_ready,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {SINGLE, DBL_HI, DBL_LO} state_t;

  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_LDUB = 6'b000001;
  localparam logic [5:0] OP3_LDUH = 6'b000010;
  localparam logic [5:0] OP3_LDD  = 6'b000011;
  localparam logic [5:0] OP3_LDSB = 6'b001001;
  localparam logic [5:0] OP3_LDSH = 6'b001010;

  state_t      state, state_n;

  logic [4:0]  s_regD;
  logic [63:0] s_alu;
  logic [63:0] s_data;
  logic [1:0]  s_op;
  logic [2:0]  s_op2;
  logic [5:0]  s_op3;
  logic        s_rw;
  logic        s_rwd;
  logic [3:0]  s_icc;
  logic        s_iccw;
  logic [31:0] s_y;
  logic        s_yw;
  logic [31:0] count_q;

  function automatic logic is_load(input logic [1:0] op, input logic [5:0] op3);
    logic r;
    r = 1'b0;
    if (op == 2'b11) begin
      case (op3)
        OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_LDSB, OP3_LDSH: r = 1'b1;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_store(input logic [1:0] op, input logic [5:0] op3);
    return (op == 2'b11) && (op3[5:2] == 4'b0001);
  endfunction

  function automatic logic is_double(input logic [1:0] op, input logic [5:0] op3, input logic rwd);
    return ((op == 2'b11) && (op3 == OP3_LDD)) || (rwd && !is_store(op, op3));
  endfunction

  logic        s_nop, s_ld, s_ldd, s_st, misalign, wr_single, in_double, retire;
  logic [2:0]  k;
  logic [63:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    s_nop     = (s_op == 2'b00) && (s_op2 == 3'b100) && (s_regD == 5'd0);
    s_ld      = is_load(s_op, s_op3);
    s_st      = is_store(s_op, s_op3);
    s_ldd     = s_ld && (s_op3 == OP3_LDD);
    k         = s_alu[2:0];
    // Shifting the selected byte lane to the top makes every width a fixed slice.
    shifted   = s_data << {k, 3'b000};
    wr_single = !s_nop && (s_ld || (s_rw && !s_st));
    in_double = is_double(Wb_op_in, Wb_op3_in, Wb_regWriteDouble_in);

    load_val = shifted[63:32];
    misalign = 1'b0;
    if (s_ld) begin
      case (s_op3)
        OP3_LDUB: load_val = {24'd0, shifted[63:56]};
        OP3_LDSB: load_val = {{24{shifted[63]}}, shifted[63:56]};
        OP3_LDUH: begin
          load_val = {16'd0, shifted[63:48]};
          misalign = k[0];
        end
        OP3_LDSH: begin
          load_val = {{16{shifted[63]}}, shifted[63:48]};
          misalign = k[0];
        end
        OP3_LD:  misalign = (k[1:0] != 2'b00);
        OP3_LDD: misalign = (k != 3'd0);
        default: load_val = shifted[63:32];
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = s_regD;
    rf_wdata = s_ld ? load_val : s_alu[31:0];
    icc_we   = 1'b0;
    y_we     = 1'b0;
    wb_ready = (state != DBL_HI);
    retire   = 1'b0;
    state_n  = state;
    case (state)
      SINGLE: begin
        rf_we   = wr_single && !misalign;
        icc_we  = s_iccw && !s_nop;
        y_we    = s_yw && !s_nop;
        retire  = !s_nop;
        state_n = in_double ? DBL_HI : SINGLE;
      end
      DBL_HI: begin
        rf_waddr = {s_regD[4:1], 1'b0};
        rf_wdata = s_ldd ? s_data[63:32] : s_alu[63:32];
        rf_we    = !misalign;
        icc_we   = s_iccw;
        y_we     = s_yw;
        state_n  = DBL_LO;
      end
      DBL_LO: begin
        rf_waddr = {s_regD[4:1], 1'b1};
        rf_wdata = s_ldd ? s_data[31:0] : s_alu[31:0];
        rf_we    = !misalign;
        retire   = 1'b1;
        state_n  = in_double ? DBL_HI : SINGLE;
      end
      default: state_n = SINGLE;
    endcase
    if (rf_waddr == 5'd0) rf_we = 1'b0;
  end

  assign icc_out       = s_icc;
  assign y_out         = s_y;
  assign retired_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SINGLE;
      s_regD  <= '0;
      s_alu   <= '0;
      s_data  <= '0;
      s_op    <= '0;
      s_op2   <= 3'b100;
      s_op3   <= '0;
      s_rw    <= 1'b0;
      s_rwd   <= 1'b0;
      s_icc   <= '0;
      s_iccw  <= 1'b0;
      s_y     <= '0;
      s_yw    <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_q + {31'd0, retire};
      if (wb_ready) begin
        s_regD <= Wb_regD_in;
        s_alu  <= Wb_alures_in;
        s_data <= Wb_load_data_in;
        s_op   <= Wb_op_in;
        s_op2  <= Wb_op2_in;
        s_op3  <= Wb_op3_in;
        s_rw   <= Wb_regWrite_in;
        s_rwd  <= Wb_regWriteDouble_in;
        s_icc  <= Wb_icc_in;
        s_iccw <= Wb_icc_write_in;
        s_y    <= Wb_Y_in;
        s_yw   <= Wb_Y_write_in;
      end
    end
  end

  // Double-ness is latched into the FSM state; the flag itself is kept only for completeness.
  logic unused_rwd;
  assign unused_rwd = s_rwd;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expected values.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  regD;
  logic [63:0] alures, ldata;
  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic        rw, rwd, iccw, yw;
  logic [3:0]  icc;
  logic [31:0] yv;
  logic        rf_we, icc_we, y_we, wb_ready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, y_out, retired_count;
  logic [3:0]  icc_out;

  int total = 0;
  int bad   = 0;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .Wb_regD_in(regD), .Wb_alures_in(alures), .Wb_load_data_in(ldata),
    .Wb_op_in(op), .Wb_op2_in(op2), .Wb_op3_in(op3),
    .Wb_regWrite_in(rw), .Wb_regWriteDouble_in(rwd),
    .Wb_icc_in(icc), .Wb_icc_write_in(iccw), .Wb_Y_in(yv), .Wb_Y_write_in(yw),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .icc_we(icc_we), .icc_out(icc_out), .y_we(y_we), .y_out(y_out),
    .wb_ready(wb_ready), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [2:0] o2, input logic [5:0] o3,
                       input logic [4:0] d, input logic [63:0] a, input logic [63:0] m,
                       input logic w, input logic wd, input logic [3:0] c, input logic cw,
                       input logic [31:0] y, input logic ywr);
    op = o; op2 = o2; op3 = o3; regD = d; alures = a; ldata = m;
    rw = w; rwd = wd; icc = c; iccw = cw; yv = y; yw = ywr;
  endtask

  task automatic nop();
    drive(2'b00, 3'b100, 6'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a live ADD on the inputs: reset must win over capture.
    reset = 1'b1;
    drive(2'b10, 3'b000, 6'd0, 5'd3, 64'd5, 64'd0, 1'b1, 1'b0, 4'hA, 1'b1, 32'h1234, 1'b1);
    tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_icc_we", icc_we, 0);
    chk("rst_y_we", y_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_icc_out", icc_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_count", retired_count, 0);

    reset = 1'b0;
    nop();
    tick();
    chk("nop_rf_we", rf_we, 0);
    chk("nop_count", retired_count, 0);

    // ADD r3 with icc and Y updates
    drive(2'b10, 3'b000, 6'd0, 5'd3, 64'hFFFF0000_12345678, 64'd0, 1'b1, 1'b0, 4'hA, 1'b1, 32'hCAFE0001, 1'b1);
    tick();
    chk("add_we", rf_we, 1);
    chk("add_waddr", rf_waddr, 3);
    chk("add_wdata", rf_wdata, 32'h12345678);
    chk("add_icc_we", icc_we, 1);
    chk("add_icc", icc_out, 4'hA);
    chk("add_y_we", y_we, 1);
    chk("add_y", y_out, 32'hCAFE0001);
    chk("add_count", retired_count, 0);

    // LDSB k=3 -> byte 0x80 sign-extended
    drive(2'b11, 3'b000, 6'b001001, 5'd5, 64'd3, 64'h00000080_11223344, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("ldsb_we", rf_we, 1);
    chk("ldsb_waddr", rf_waddr, 5);
    chk("ldsb_wdata", rf_wdata, 32'hFFFFFF80);
    chk("ldsb_icc_we", icc_we, 0);
    chk("ldsb_y_we", y_we, 0);
    chk("ldsb_count", retired_count, 1);

    // LDUB same byte, zero-extended
    drive(2'b11, 3'b000, 6'b000001, 5'd5, 64'd3, 64'h00000080_11223344, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("ldub_wdata", rf_wdata, 32'h00000080);
    chk("ldub_count", retired_count, 2);

    // LDUH k=2 -> data[47:32]
    drive(2'b11, 3'b000, 6'b000010, 5'd9, 64'd2, 64'h11228899_AABBCCDD, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("lduh_we", rf_we, 1);
    chk("lduh_wdata", rf_wdata, 32'h00008899);

    // LDSH k=6 -> data[15:0] sign-extended
    drive(2'b11, 3'b000, 6'b001010, 5'd9, 64'd6, 64'h11228899_AABBCCDD, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("ldsh_wdata", rf_wdata, 32'hFFFFCCDD);

    // LD k=4 -> low word
    drive(2'b11, 3'b000, 6'b000000, 5'd10, 64'd4, 64'h11228899_AABBCCDD, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("ld_waddr", rf_waddr, 10);
    chk("ld_wdata", rf_wdata, 32'hAABBCCDD);
    chk("ld_count", retired_count, 5);

    // Misaligned LDSH k=1: no rf write, icc still written
    drive(2'b11, 3'b000, 6'b001010, 5'd9, 64'd1, 64'h11228899_AABBCCDD, 1'b1, 1'b0, 4'h5, 1'b1, 32'd0, 1'b0);
    tick();
    chk("mis_we", rf_we, 0);
    chk("mis_icc_we", icc_we, 1);
    chk("mis_icc", icc_out, 4'h5);

    // Store never writes rf
    drive(2'b11, 3'b000, 6'b000100, 5'd11, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("st_we", rf_we, 0);
    chk("st_count", retired_count, 7);

    // ADD to r0: suppressed, still retires
    drive(2'b10, 3'b000, 6'd0, 5'd0, 64'd5, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("r0_we", rf_we, 0);
    chk("r0_count", retired_count, 8);

    // LDD r6 followed by a held LD r12
    drive(2'b11, 3'b000, 6'b000011, 5'd6, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 4'h3, 1'b1, 32'h77, 1'b1);
    tick();
    chk("ldd_hi_ready", wb_ready, 0);
    chk("ldd_hi_we", rf_we, 1);
    chk("ldd_hi_waddr", rf_waddr, 6);
    chk("ldd_hi_wdata", rf_wdata, 32'hDEADBEEF);
    chk("ldd_hi_icc_we", icc_we, 1);
    chk("ldd_hi_y_we", y_we, 1);
    chk("ldd_hi_count", retired_count, 9);
    drive(2'b11, 3'b000, 6'b000000, 5'd12, 64'd0, 64'h01020304_05060708, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("ldd_lo_ready", wb_ready, 1);
    chk("ldd_lo_we", rf_we, 1);
    chk("ldd_lo_waddr", rf_waddr, 7);
    chk("ldd_lo_wdata", rf_wdata, 32'hCAFEF00D);
    chk("ldd_lo_icc_we", icc_we, 0);
    chk("ldd_lo_y_we", y_we, 0);
    chk("ldd_lo_count", retired_count, 9);
    tick();
    chk("held_ld_we", rf_we, 1);
    chk("held_ld_waddr", rf_waddr, 12);
    chk("held_ld_wdata", rf_wdata, 32'h01020304);
    chk("held_ld_count", retired_count, 10);
    nop();
    tick();
    chk("after_ld_we", rf_we, 0);
    chk("after_ld_count", retired_count, 11);
    tick();
    chk("no_dup_count", retired_count, 11);

    // Non-load double write via regWriteDouble, odd regD
    drive(2'b10, 3'b000, 6'd0, 5'd9, 64'h11111111_22222222, 64'd0, 1'b1, 1'b1, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("dw_hi_ready", wb_ready, 0);
    chk("dw_hi_waddr", rf_waddr, 8);
    chk("dw_hi_wdata", rf_wdata, 32'h11111111);
    nop();
    tick();
    chk("dw_lo_we", rf_we, 1);
    chk("dw_lo_waddr", rf_waddr, 9);
    chk("dw_lo_wdata", rf_wdata, 32'h22222222);
    tick();
    chk("dw_count", retired_count, 12);

    // Misaligned LDD: both halves suppressed, FSM still steps
    drive(2'b11, 3'b000, 6'b000011, 5'd6, 64'd4, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("mldd_hi_we", rf_we, 0);
    chk("mldd_hi_ready", wb_ready, 0);
    nop();
    tick();
    chk("mldd_lo_we", rf_we, 0);
    chk("mldd_lo_ready", wb_ready, 1);
    tick();
    chk("mldd_count", retired_count, 13);

    // Reset during DBL_HI abandons the low word
    drive(2'b11, 3'b000, 6'b000011, 5'd6, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("rhi_ready", wb_ready, 0);
    reset = 1'b1;
    tick();
    chk("rhi_we", rf_we, 0);
    chk("rhi_ready_after", wb_ready, 1);
    chk("rhi_count", retired_count, 0);
    reset = 1'b0;
    nop();
    tick();
    chk("rhi_we2", rf_we, 0);

    // Counter wrap from a preloaded all-ones value
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    drive(2'b10, 3'b000, 6'd0, 5'd1, 64'd1, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("wrap_pre", retired_count, 32'hFFFF_FFFF);
    nop();
    tick();
    chk("wrap_post", retired_count, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
